memdisplay_scan: RTL and testbench
==================================

Name: memdisplay_scan

Overview:
- Parametrised successor to the single-word memory display.
- Fetches words from a window of NUM_WORDS consecutive word addresses starting at BASE_ADDR. The window is walked automatically on a dwell timer, or stepped manually.
- Low 4*NUM_DIGITS bits of each captured word are shown on NUM_DIGITS active-low seven-segment displays.
- Sits between the data-memory debug read port and the board HEX outputs. Supports synchronous-read memories through READ_LAT.

Parameters:
- NUM_DIGITS, 4, number of hex digits driven (1..8).
- BASE_ADDR, 32'd252, byte address of word index 0 (word-aligned).
- NUM_WORDS, 1, words in the scan window (1..256).
- READ_LAT, 1, cycles from address change to valid datain (0 = combinational read).
- DWELL_CYCLES, 50000000, cycles each word is shown before auto-advance or refresh (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- auto_en  in  1  1 = auto-advance on dwell expiry; 0 = manual (dwell expiry refreshes the current word).
- step  in  1  single-cycle pulse, already synchronised; advance to next word.
- freeze  in  1  hold the current display; dwell counter and step ignored.
- datain  in  32  memory read data.
- address  out  32  byte address presented to memory.
- hex_n  out  7*NUM_DIGITS  segments; digit k at [7k+6:7k]; bit0 = a … bit6 = g; active low.
- word_idx  out  8  current window index.
- valid  out  1  1 once the first capture has occurred.

Behaviour:
- Reset values (async assert, sync release):
  - FSM = FETCH, idx = 0, address = BASE_ADDR, shadow = 0, valid = 0, wait and dwell counters = 0.
  - Every hex_n digit = 7'h40 (glyph "0").
- address = BASE_ADDR + 4*idx, modulo 2^32. It is registered and changes on the same edge idx changes.
- FETCH:
  - Wait counter counts 0..READ_LAT.
  - On the edge where the counter equals READ_LAT, capture datain into shadow, set valid = 1, clear the dwell counter, and go to SHOW.
  - Capture therefore happens READ_LAT+1 edges after the address-change edge.
- SHOW:
  - Dwell counter increments each cycle unless freeze = 1, in which case it holds.
  - Advance event = (step && !freeze) || (dwell == DWELL_CYCLES-1 && auto_en && !freeze).
  - Refresh event = (dwell == DWELL_CYCLES-1 && !auto_en && !freeze) with no step pending.
  - On advance: idx <= (idx == NUM_WORDS-1) ? 0 : idx+1; go to FETCH.
  - On refresh: idx unchanged; go to FETCH. This live-updates the displayed word.
  - step coinciding with dwell expiry produces exactly one advance.
- Pulses on step while in FETCH are dropped and not queued.
- With NUM_WORDS = 1, an advance wraps to idx 0, so it behaves as a refresh.
- The display holds the previous shadow throughout FETCH and never shows intermediate data.
- hex_n:
  - Combinational decode of shadow: digit k shows shadow[4k+3:4k].
  - Codes for 0-F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
- freeze asserted during FETCH does not stall the fetch. The capture completes, then SHOW holds.
- Reset asserted mid-FETCH or mid-SHOW returns all outputs to reset values immediately, with no completion of the pending capture.
- word_idx is zero-extended from the internal index register.

Test Plan:
1. Reset/first capture: hold reset_n = 0 → address = 252, hex_n = {4{7'h40}}, valid = 0. Release with datain = 32'h0000BEEF, READ_LAT = 1 → on the 2nd rising edge, valid = 1 and hex3..0 = 7'h03, 7'h06, 7'h06, 7'h0E.
2. Live refresh: NUM_WORDS = 1, DWELL_CYCLES = 4, auto_en = 0. Change datain to 32'h1234 while in SHOW → display updates after 4 dwell cycles + 2 fetch cycles; address stays 252.
3. Auto scan with wrap: NUM_WORDS = 3, auto_en = 1, memory model returns the address as data → address sequence 252, 256, 260, 252. Displayed digits track 00FC, 0100, 0104, 00FC; word_idx goes 0, 1, 2, 0.
4. Manual step:
   - auto_en = 0, NUM_WORDS = 3; a step pulse in SHOW → idx 1 and address 256 on the next edge.
   - A second step during that FETCH is ignored (idx stays 1 after capture).
5. Freeze: freeze = 1 in SHOW for 20 cycles with auto_en = 1 and DWELL_CYCLES = 4, step pulsed → address, idx and hex_n unchanged. Release → advance after 4 more cycles.
6. Reset mid-fetch: drive reset_n = 0 one cycle after an advance to idx 2 → address = 252, idx = 0, valid = 0, hex_n all 7'h40 asynchronously.

Source files
------------

// File: rtl/memdisplay_scan.sv
// Scans a window of memory words onto active-low seven-segment displays,
// advancing on a dwell timer or a manual step and refreshing in place otherwise.
module memdisplay_scan #(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'd252,
    parameter int          NUM_WORDS    = 1,
    parameter int          READ_LAT     = 1,
    parameter int          DWELL_CYCLES = 50000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    auto_en,
    input  logic                    step,
    input  logic                    freeze,
    input  logic [31:0]             datain,
    output logic [31:0]             address,
    output logic [7*NUM_DIGITS-1:0] hex_n,
    output logic [7:0]              word_idx,
    output logic                    valid
);

    localparam int WAIT_W  = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam int DWELL_W = $clog2(DWELL_CYCLES);

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(READ_LAT);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [7:0]         IDX_LAST   = 8'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t               state_r;
    logic [WAIT_W-1:0]    wait_r;
    logic [DWELL_W-1:0]   dwell_r;
    logic [7:0]           idx_r;
    logic [31:0]          address_r;
    logic [31:0]          shadow_r;
    logic                 valid_r;

    logic                 expire_s;
    logic                 advance_s;
    logic                 refresh_s;
    logic [7:0]           idx_next_s;
    logic [7*NUM_DIGITS-1:0] hex_s;

    // Active-low segment pattern (bit0 = a ... bit6 = g) for one hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Dwell expiry, step handling and the wrapped next window index.
    always_comb begin
        expire_s   = (dwell_r == DWELL_LAST);
        advance_s  = !freeze && (step || (expire_s && auto_en));
        refresh_s  = !freeze && expire_s && !auto_en && !step;
        if (idx_r == IDX_LAST) begin
            idx_next_s = 8'd0;
        end else begin
            idx_next_s = idx_r + 8'd1;
        end
    end

    // Fetch/show sequencer; address moves on the same edge as the index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_FETCH;
            wait_r    <= '0;
            dwell_r   <= '0;
            idx_r     <= 8'd0;
            address_r <= BASE_ADDR;
            shadow_r  <= 32'd0;
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // freeze is deliberately ignored here so a fetch always lands
                    if (wait_r == WAIT_LAST) begin
                        shadow_r <= datain;
                        valid_r  <= 1'b1;
                        dwell_r  <= '0;
                        wait_r   <= '0;
                        state_r  <= ST_SHOW;
                    end else begin
                        wait_r <= wait_r + WAIT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (advance_s) begin
                        idx_r     <= idx_next_s;
                        address_r <= BASE_ADDR + {22'd0, idx_next_s, 2'b00};
                        wait_r    <= '0;
                        state_r   <= ST_FETCH;
                    end else if (refresh_s) begin
                        wait_r  <= '0;
                        state_r <= ST_FETCH;
                    end else if (!freeze) begin
                        dwell_r <= dwell_r + DWELL_W'(1);
                    end else begin
                        dwell_r <= dwell_r;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                    wait_r  <= '0;
                end
            endcase
        end
    end

    // Decode the captured word; digits above NUM_DIGITS are simply not shown.
    always_comb begin
        hex_s = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hex_s[7*k +: 7] = seg7(shadow_r[4*k +: 4]);
        end
    end

    logic unused_shadow_s;
    assign unused_shadow_s = &{1'b0, shadow_r};

    assign hex_n    = hex_s;
    assign address  = address_r;
    assign word_idx = idx_r;
    assign valid    = valid_r;

endmodule

// File: tb/tb_memdisplay_scan.sv
// Directed bench: a single-word instance for capture/refresh and a three-word
// instance fed by a one-cycle-latency memory model for scan, step, freeze, reset.
module tb_memdisplay_scan;

    localparam logic [27:0] HEX_ZERO = {4{7'h40}};
    localparam logic [27:0] HEX_BEEF = {7'h03, 7'h06, 7'h06, 7'h0E};
    localparam logic [27:0] HEX_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] HEX_00FC = {7'h40, 7'h40, 7'h0E, 7'h46};
    localparam logic [27:0] HEX_0100 = {7'h40, 7'h79, 7'h40, 7'h40};
    localparam logic [27:0] HEX_0104 = {7'h40, 7'h79, 7'h40, 7'h19};

    logic        clk;
    logic        reset_n;
    logic        auto_en;
    logic        step;
    logic        freeze;
    logic [31:0] data_a;
    logic [31:0] addr_a;
    logic [27:0] hex_a;
    logic [7:0]  idx_a;
    logic        valid_a;
    logic [31:0] mem_q;
    logic [31:0] addr_b;
    logic [27:0] hex_b;
    logic [7:0]  idx_b;
    logic        valid_b;

    int n_checks;
    int n_fail;

    logic [31:0] scan_addr [4];
    logic [7:0]  scan_idx  [4];
    logic [27:0] scan_hex  [4];

    memdisplay_scan #(
        .NUM_DIGITS(4), .BASE_ADDR(32'd252), .NUM_WORDS(1),
        .READ_LAT(1), .DWELL_CYCLES(4)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .auto_en(auto_en), .step(step),
        .freeze(freeze), .datain(data_a), .address(addr_a), .hex_n(hex_a),
        .word_idx(idx_a), .valid(valid_a)
    );

    memdisplay_scan #(
        .NUM_DIGITS(4), .BASE_ADDR(32'd252), .NUM_WORDS(3),
        .READ_LAT(1), .DWELL_CYCLES(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .auto_en(auto_en), .step(step),
        .freeze(freeze), .datain(mem_q), .address(addr_b), .hex_n(hex_b),
        .word_idx(idx_b), .valid(valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory whose contents equal the byte address.
    always_ff @(posedge clk) begin
        mem_q <= addr_b;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        scan_addr[0] = 32'd252; scan_idx[0] = 8'd0; scan_hex[0] = HEX_00FC;
        scan_addr[1] = 32'd256; scan_idx[1] = 8'd1; scan_hex[1] = HEX_0100;
        scan_addr[2] = 32'd260; scan_idx[2] = 8'd2; scan_hex[2] = HEX_0104;
        scan_addr[3] = 32'd252; scan_idx[3] = 8'd0; scan_hex[3] = HEX_00FC;

        reset_n = 1'b0; auto_en = 1'b0; step = 1'b0; freeze = 1'b0;
        data_a  = 32'h0000BEEF;
        repeat (3) @(negedge clk);
        check_val("rst_addr",  addr_a, 32'd252);
        check_val("rst_hex",   {4'd0, hex_a}, {4'd0, HEX_ZERO});
        check_val("rst_valid", {31'd0, valid_a}, 32'd0);
        check_val("rst_idx",   {24'd0, idx_b}, 32'd0);

        // first capture lands on the second edge after release
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_val("cap_edge1_valid", {31'd0, valid_a}, 32'd0);
        @(posedge clk); #1;
        check_val("cap_edge2_valid", {31'd0, valid_a}, 32'd1);
        check_val("cap_beef", {4'd0, hex_a}, {4'd0, HEX_BEEF});

        // live refresh: 4 dwell cycles then 2 fetch cycles
        data_a = 32'h00001234;
        repeat (5) @(posedge clk); #1;
        check_val("refresh_hold", {4'd0, hex_a}, {4'd0, HEX_BEEF});
        check_val("refresh_addr", addr_a, 32'd252);
        @(posedge clk); #1;
        check_val("refresh_new", {4'd0, hex_a}, {4'd0, HEX_1234});
        check_val("refresh_idx", {24'd0, idx_a}, 32'd0);

        // auto scan with wrap on the three-word instance
        @(negedge clk);
        reset_n = 1'b0; auto_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("scan%0d_addr", i), addr_b, scan_addr[i]);
            check_val($sformatf("scan%0d_idx", i), {24'd0, idx_b}, {24'd0, scan_idx[i]});
            check_val($sformatf("scan%0d_hex", i), {4'd0, hex_b}, {4'd0, scan_hex[i]});
            if (i < 3) begin
                repeat (5) @(posedge clk); #1;
                check_val($sformatf("scan%0d_fetch_hold", i), {4'd0, hex_b}, {4'd0, scan_hex[i]});
                @(posedge clk); #1;
            end
        end

        // manual step; a second step during the fetch is dropped
        auto_en = 1'b0; step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        check_val("step_idx",  {24'd0, idx_b}, 32'd1);
        check_val("step_addr", addr_b, 32'd256);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        @(posedge clk); #1;
        check_val("step_drop_idx",  {24'd0, idx_b}, 32'd1);
        check_val("step_drop_addr", addr_b, 32'd256);
        check_val("step_drop_hex",  {4'd0, hex_b}, {4'd0, HEX_0100});

        // freeze in SHOW holds everything, even with a step pulse
        freeze = 1'b1; auto_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            step = (i == 10);
        end
        step = 1'b0;
        check_val("freeze_idx",  {24'd0, idx_b}, 32'd1);
        check_val("freeze_addr", addr_b, 32'd256);
        check_val("freeze_hex",  {4'd0, hex_b}, {4'd0, HEX_0100});
        freeze = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_val("unfreeze_wait_addr", addr_b, 32'd256);
        @(posedge clk); #1;
        check_val("unfreeze_adv_addr", addr_b, 32'd260);
        check_val("unfreeze_adv_idx",  {24'd0, idx_b}, 32'd2);

        // reset in the middle of the fetch of word 2
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_val("midrst_addr",  addr_b, 32'd252);
        check_val("midrst_idx",   {24'd0, idx_b}, 32'd0);
        check_val("midrst_valid", {31'd0, valid_b}, 32'd0);
        check_val("midrst_hex",   {4'd0, hex_b}, {4'd0, HEX_ZERO});
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
